// File: rtl/fetch_decode_exec.sv
`default_nettype none
// ============================================================================
// fetch_decode_exec : RV32I fetch / decode / execute front half (multi-cycle).
// Optional macro FDE_MUL_EN enables the OP/MUL encoding.   Rev 1.0
// ============================================================================
module fetch_decode_exec #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enabled,
  input  logic [31:0] pc,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic        completed,
  output logic [4:0]  rd,
  output logic        reg_write,
  output logic        is_load,
  output logic        is_store,
  output logic [2:0]  funct3,
  output logic [31:0] store_data,
  output logic [31:0] result,
  output logic        is_jump_chosen,
  output logic [31:0] next_pc,
  output logic        illegal
);
  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, LATCH = 2'd2, EXEC = 2'd3} state_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic        reg_write;
    logic        is_load;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] store_data;
    logic [31:0] result;
    logic        is_jump_chosen;
    logic [31:0] next_pc;
    logic        illegal;
  } exec_out_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  state_t      state_q, state_d;
  logic [31:0] rom_addr_q, rom_addr_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic        completed_q, completed_d;
  exec_out_t   out_q, out_d, ex;

  logic [6:0]  opcode, funct7;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] pc_plus4, alu_b, alu_y;
  logic [4:0]  shamt;
  logic        alt, take;

  assign opcode   = ir_q[6:0];
  assign f3       = ir_q[14:12];
  assign funct7   = ir_q[31:25];
  assign imm_i    = {{20{ir_q[31]}}, ir_q[31:20]};
  assign imm_s    = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
  assign imm_b    = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
  assign imm_u    = {ir_q[31:12], 12'h000};
  assign imm_j    = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
  assign pc_plus4 = pc_q + 32'd4;
  assign alu_b    = (opcode == OPC_OP) ? rs2_data : imm_i;
  assign shamt    = alu_b[4:0];
  // Bit 30 picks SUB only for register-register ops; for shifts it picks SRA in both forms
  assign alt      = funct7[5];

`ifdef FDE_MUL_EN
  logic [31:0] mul_lo;
  assign mul_lo = rs1_data * rs2_data;
`endif

  always_comb begin
    alu_y = '0;
    case (f3)
      3'b000:  alu_y = (opcode == OPC_OP && alt) ? rs1_data - alu_b : rs1_data + alu_b;
      3'b001:  alu_y = rs1_data << shamt;
      3'b010:  alu_y = {31'd0, $signed(rs1_data) < $signed(alu_b)};
      3'b011:  alu_y = {31'd0, rs1_data < alu_b};
      3'b100:  alu_y = rs1_data ^ alu_b;
      3'b101:  alu_y = alt ? 32'($signed(rs1_data) >>> shamt) : rs1_data >> shamt;
      3'b110:  alu_y = rs1_data | alu_b;
      default: alu_y = rs1_data & alu_b;
    endcase
  end

  always_comb begin
    ex         = '0;
    ex.rd      = ir_q[11:7];
    ex.funct3  = f3;
    ex.next_pc = pc_plus4;
    take       = 1'b0;
    case (opcode)
      OPC_LUI:   begin ex.reg_write = 1'b1; ex.result = imm_u; end
      OPC_AUIPC: begin ex.reg_write = 1'b1; ex.result = pc_q + imm_u; end
      OPC_JAL: begin
        ex.reg_write = 1'b1; ex.is_jump_chosen = 1'b1;
        ex.result = pc_plus4; ex.next_pc = pc_q + imm_j;
      end
      OPC_JALR: begin
        ex.illegal = (f3 != 3'b000);
        ex.reg_write = 1'b1; ex.is_jump_chosen = 1'b1;
        ex.result = pc_plus4; ex.next_pc = (rs1_data + imm_i) & ~32'd1;
      end
      OPC_BRANCH: begin
        case (f3)
          3'b000:  take = (rs1_data == rs2_data);
          3'b001:  take = (rs1_data != rs2_data);
          3'b100:  take = ($signed(rs1_data) <  $signed(rs2_data));
          3'b101:  take = ($signed(rs1_data) >= $signed(rs2_data));
          3'b110:  take = (rs1_data <  rs2_data);
          3'b111:  take = (rs1_data >= rs2_data);
          default: ex.illegal = 1'b1;
        endcase
        if (take) begin ex.is_jump_chosen = 1'b1; ex.next_pc = pc_q + imm_b; end
      end
      OPC_LOAD: begin
        ex.illegal = (f3 == 3'b011) || (f3[2:1] == 2'b11);
        ex.is_load = 1'b1; ex.reg_write = 1'b1; ex.result = rs1_data + imm_i;
      end
      OPC_STORE: begin
        ex.illegal = f3[2] || (f3 == 3'b011);
        ex.is_store = 1'b1; ex.result = rs1_data + imm_s; ex.store_data = rs2_data;
      end
      OPC_OPIMM: begin
        ex.illegal = ((f3 == 3'b001) && (funct7 != 7'b0000000)) ||
                     ((f3 == 3'b101) && (funct7 != 7'b0000000) && (funct7 != 7'b0100000));
        ex.reg_write = 1'b1; ex.result = alu_y;
      end
      OPC_OP: begin
        ex.reg_write = 1'b1; ex.result = alu_y;
        case (funct7)
          7'b0000000: ex.illegal = 1'b0;
          7'b0100000: ex.illegal = !((f3 == 3'b000) || (f3 == 3'b101));
`ifdef FDE_MUL_EN
          7'b0000001: begin ex.illegal = (f3 != 3'b000); ex.result = mul_lo; end
`endif
          default:    ex.illegal = 1'b1;
        endcase
      end
      default: ex.illegal = 1'b1;
    endcase
    // Illegal encodings keep only the raw rd/funct3 fields and fall through to pc+4
    if (ex.illegal) begin
      ex.reg_write = 1'b0; ex.is_load = 1'b0; ex.is_store = 1'b0; ex.is_jump_chosen = 1'b0;
      ex.result = '0; ex.store_data = '0; ex.next_pc = pc_plus4;
    end
    if (ex.rd == 5'd0) ex.reg_write = 1'b0;
  end

  always_comb begin
    state_d     = state_q;
    rom_addr_d  = rom_addr_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    out_d       = out_q;
    completed_d = 1'b0;
    case (state_q)
      IDLE: if (enabled) begin
        rom_addr_d = pc; pc_d = pc; state_d = FETCH;
      end
      FETCH: state_d = LATCH;
      LATCH: begin ir_d = rom_data; state_d = EXEC; end
      default: begin out_d = ex; completed_d = 1'b1; state_d = IDLE; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rom_addr_q  <= RESET_PC;
      pc_q        <= '0;
      ir_q        <= '0;
      out_q       <= '0;
      completed_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rom_addr_q  <= rom_addr_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      out_q       <= out_d;
      completed_q <= completed_d;
    end
  end

  assign rom_addr       = rom_addr_q;
  assign rs1_addr       = ir_q[19:15];
  assign rs2_addr       = ir_q[24:20];
  assign completed      = completed_q;
  assign rd             = out_q.rd;
  assign reg_write      = out_q.reg_write;
  assign is_load        = out_q.is_load;
  assign is_store       = out_q.is_store;
  assign funct3         = out_q.funct3;
  assign store_data     = out_q.store_data;
  assign result         = out_q.result;
  assign is_jump_chosen = out_q.is_jump_chosen;
  assign next_pc        = out_q.next_pc;
  assign illegal        = out_q.illegal;
endmodule
`default_nettype wire

// File: tb/tb_fetch_decode_exec.sv
`default_nettype none
// tb_fetch_decode_exec : directed RV32I vectors; an ISA-level model is compared
// against the DUT every cycle, plus literal expectations per vector.
module tb_fetch_decode_exec;
  localparam logic [31:0] RESET_PC = 32'h0000_0040;

  typedef struct packed {
    logic [4:0]  rd;
    logic        rw, ld, st;
    logic [2:0]  f3;
    logic [31:0] sd, res;
    logic        jmp;
    logic [31:0] npc;
    logic        ill;
  } out_t;

  typedef struct packed {
    logic [31:0] pc, ins, r1, r2, res, npc;
    logic [4:0]  rd;
    logic [4:0]  fl;   // {reg_write, is_load, is_store, is_jump_chosen, illegal}
  } vec_t;

  logic        clk = 1'b0, rst = 1'b1, enabled = 1'b0;
  logic [31:0] pc = '0, rom_addr, rom_data = '0, rs1_data, rs2_data;
  logic [4:0]  rs1_addr, rs2_addr, rd;
  logic        completed, reg_write, is_load, is_store, is_jump_chosen, illegal;
  logic [2:0]  funct3;
  logic [31:0] store_data, result, next_pc;
  logic [31:0] regs [32];
  logic [31:0] tb_pc = 32'hFFFF_FFF0, tb_instr = '0;
  int          checks = 0, errors = 0;
  vec_t        vecs[$];

  always #5 clk = ~clk;

  fetch_decode_exec #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .enabled(enabled), .pc(pc),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .completed(completed), .rd(rd), .reg_write(reg_write), .is_load(is_load),
    .is_store(is_store), .funct3(funct3), .store_data(store_data), .result(result),
    .is_jump_chosen(is_jump_chosen), .next_pc(next_pc), .illegal(illegal)
  );

  assign rs1_data = regs[rs1_addr];
  assign rs2_data = regs[rs2_addr];
  // Synchronous ROM holding one instruction at tb_pc; anything else reads as 0
  always @(posedge clk) rom_data <= (rom_addr == tb_pc) ? tb_instr : 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] alu(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                                      input logic alt);
    case (f)
      3'd0:    return alt ? a - b : a + b;
      3'd1:    return a << b[4:0];
      3'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3:    return (a < b) ? 32'd1 : 32'd0;
      3'd4:    return a ^ b;
      3'd5:    return alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6:    return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic out_t model(input logic [31:0] p, input logic [31:0] ins,
                                 input logic [31:0] a, input logic [31:0] b);
    out_t o;
    logic ok, t;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] ii, is, ib, iu, ij;
    f3 = ins[14:12]; f7 = ins[31:25];
    ii = {{20{ins[31]}}, ins[31:20]};
    is = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    ib = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    iu = {ins[31:12], 12'h000};
    ij = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    o = '0; o.rd = ins[11:7]; o.f3 = f3; o.npc = p + 32'd4; ok = 1'b1; t = 1'b0;
    case (ins[6:0])
      7'h37: begin o.rw = 1'b1; o.res = iu; end
      7'h17: begin o.rw = 1'b1; o.res = p + iu; end
      7'h6F: begin o.rw = 1'b1; o.jmp = 1'b1; o.res = p + 32'd4; o.npc = p + ij; end
      7'h67: begin
        ok = (f3 == 3'd0); o.rw = 1'b1; o.jmp = 1'b1; o.res = p + 32'd4; o.npc = (a + ii) & 32'hFFFF_FFFE;
      end
      7'h63: begin
        case (f3)
          3'd0: t = (a == b);
          3'd1: t = (a != b);
          3'd4: t = $signed(a) < $signed(b);
          3'd5: t = !($signed(a) < $signed(b));
          3'd6: t = a < b;
          3'd7: t = !(a < b);
          default: ok = 1'b0;
        endcase
        if (t) begin o.jmp = 1'b1; o.npc = p + ib; end
      end
      7'h03: begin
        ok = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
        o.ld = 1'b1; o.rw = 1'b1; o.res = a + ii;
      end
      7'h23: begin ok = (f3 <= 3'd2); o.st = 1'b1; o.res = a + is; o.sd = b; end
      7'h13: begin
        if (f3 == 3'd1)      ok = (f7 == 7'h00);
        else if (f3 == 3'd5) ok = (f7 == 7'h00) || (f7 == 7'h20);
        o.rw = 1'b1; o.res = alu(f3, a, ii, (f3 == 3'd5) && ins[30]);
      end
      7'h33: begin
        o.rw = 1'b1;
        if (f7 == 7'h00) o.res = alu(f3, a, b, 1'b0);
        else if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) o.res = alu(f3, a, b, 1'b1);
`ifdef FDE_MUL_EN
        else if (f7 == 7'h01 && f3 == 3'd0) o.res = a * b;
`endif
        else ok = 1'b0;
      end
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      o.rw = 1'b0; o.ld = 1'b0; o.st = 1'b0; o.jmp = 1'b0; o.res = '0; o.sd = '0;
      o.npc = p + 32'd4; o.ill = 1'b1;
    end
    if (o.rd == 5'd0) o.rw = 1'b0;
    return o;
  endfunction

  // Per-cycle comparison against the model: completion timing, held outputs, ROM address
  initial begin : monitor
    int   cyc, due;
    logic armed;
    out_t exp_o, pend;
    logic [31:0] exp_rom, pend_ins;
    logic [4:0]  exp_rs1, exp_rs2;
    cyc = 0; due = -1; armed = 1'b0; exp_o = '0; pend = '0;
    exp_rom = RESET_PC; pend_ins = '0; exp_rs1 = '0; exp_rs2 = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (armed) begin
        if (cyc == due) exp_o = pend;
        if (cyc == due - 1) begin exp_rs1 = pend_ins[19:15]; exp_rs2 = pend_ins[24:20]; end
        chk("mon_completed", 32'(completed), 32'(cyc == due));
        chk("mon_rom_addr", rom_addr, exp_rom);
        if (cyc >= due - 1) begin
          chk("mon_rs1_addr", 32'(rs1_addr), 32'(exp_rs1));
          chk("mon_rs2_addr", 32'(rs2_addr), 32'(exp_rs2));
        end
        chk("mon_rd", 32'(rd), 32'(exp_o.rd));
        chk("mon_reg_write", 32'(reg_write), 32'(exp_o.rw));
        chk("mon_is_load", 32'(is_load), 32'(exp_o.ld));
        chk("mon_is_store", 32'(is_store), 32'(exp_o.st));
        chk("mon_funct3", 32'(funct3), 32'(exp_o.f3));
        chk("mon_store_data", store_data, exp_o.sd);
        chk("mon_result", result, exp_o.res);
        chk("mon_jump", 32'(is_jump_chosen), 32'(exp_o.jmp));
        chk("mon_next_pc", next_pc, exp_o.npc);
        chk("mon_illegal", 32'(illegal), 32'(exp_o.ill));
      end
      if (rst) begin
        armed = 1'b1; due = -1; exp_o = '0; exp_rom = RESET_PC; exp_rs1 = '0; exp_rs2 = '0;
      end else if (armed && enabled && cyc >= due) begin
        due      = cyc + 4;
        exp_rom  = pc;
        pend_ins = (pc == tb_pc) ? tb_instr : 32'h0;
        pend     = model(pc, pend_ins, regs[pend_ins[19:15]], regs[pend_ins[24:20]]);
      end
    end
  end

  task automatic run_vec(input int idx, input vec_t v, input logic glitch);
    int n;
    for (int i = 1; i < 32; i++) regs[i] = '0;
    if (v.ins[19:15] != 5'd0) regs[v.ins[19:15]] = v.r1;
    if (v.ins[24:20] != 5'd0) regs[v.ins[24:20]] = v.r2;
    tb_pc = v.pc; tb_instr = v.ins;
    pc = v.pc; enabled = 1'b1;
    @(posedge clk); #1;
    enabled = 1'b0;
    n = 1;
    if (glitch) begin pc = 32'h0000_0500; enabled = 1'b1; end
    while (!completed && n < 8) begin
      @(posedge clk); #1;
      enabled = 1'b0;
      n++;
    end
    chk($sformatf("v%0d_latency", idx), 32'(n), 32'd4);
    chk($sformatf("v%0d_result", idx), result, v.res);
    chk($sformatf("v%0d_next_pc", idx), next_pc, v.npc);
    chk($sformatf("v%0d_rd", idx), 32'(rd), 32'(v.rd));
    chk($sformatf("v%0d_flags", idx), 32'({reg_write, is_load, is_store, is_jump_chosen, illegal}), 32'(v.fl));
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin : stimulus
    out_t m;
    logic seen;
    for (int i = 0; i < 32; i++) regs[i] = '0;
    vecs.push_back('{32'h10,   32'h00500093, 32'h0,        32'h0,        32'h5,        32'h14,   5'd1,  5'b10000});
    vecs.push_back('{32'h100,  32'hFE208EE3, 32'h7,        32'h7,        32'h0,        32'hFC,   5'd29, 5'b00010});
    vecs.push_back('{32'h100,  32'hFE208EE3, 32'h7,        32'h8,        32'h0,        32'h104,  5'd29, 5'b00000});
    vecs.push_back('{32'h20,   32'h004080E7, 32'h1001,     32'h0,        32'h24,       32'h1004, 5'd1,  5'b10010});
    vecs.push_back('{32'h24,   32'h00208033, 32'hFFFFFFFF, 32'h1,        32'h0,        32'h28,   5'd0,  5'b00000});
    vecs.push_back('{32'h30,   32'h402081B3, 32'h5,        32'h7,        32'hFFFFFFFE, 32'h34,   5'd3,  5'b10000});
    vecs.push_back('{32'h40,   32'h4040D293, 32'h80000000, 32'h0,        32'hF8000000, 32'h44,   5'd5,  5'b10000});
    vecs.push_back('{32'h50,   32'hFFF0A313, 32'h5,        32'h0,        32'h0,        32'h54,   5'd6,  5'b10000});
    vecs.push_back('{32'h54,   32'hFFF0B313, 32'h5,        32'h0,        32'h1,        32'h58,   5'd6,  5'b10000});
    vecs.push_back('{32'h60,   32'h0080A383, 32'h1000,     32'h0,        32'h1008,     32'h64,   5'd7,  5'b11000});
    vecs.push_back('{32'h64,   32'hFE20AE23, 32'h2000,     32'hCAFEBABE, 32'h1FFC,     32'h68,   5'd28, 5'b00100});
    vecs.push_back('{32'h68,   32'h010000EF, 32'h0,        32'h0,        32'h6C,       32'h78,   5'd1,  5'b10010});
    vecs.push_back('{32'h70,   32'h12345137, 32'h0,        32'h0,        32'h12345000, 32'h74,   5'd2,  5'b10000});
    vecs.push_back('{32'h1000, 32'hFFFFF197, 32'h0,        32'h0,        32'h0,        32'h1004, 5'd3,  5'b10000});
    vecs.push_back('{32'h80,   32'h0020E463, 32'h1,        32'hFFFFFFFF, 32'h0,        32'h88,   5'd8,  5'b00010});
    vecs.push_back('{32'h80,   32'h0020C463, 32'h1,        32'hFFFFFFFF, 32'h0,        32'h84,   5'd8,  5'b00000});
    vecs.push_back('{32'h90,   32'h002091B3, 32'h1,        32'h23,       32'h8,        32'h94,   5'd3,  5'b10000});
    vecs.push_back('{32'h94,   32'h0020D1B3, 32'h80000000, 32'h1,        32'h40000000, 32'h98,   5'd3,  5'b10000});
`ifdef FDE_MUL_EN
    vecs.push_back('{32'hA0,   32'h022081B3, 32'h3,        32'h5,        32'hF,        32'hA4,   5'd3,  5'b10000});
`else
    vecs.push_back('{32'hA0,   32'h022081B3, 32'h3,        32'h5,        32'h0,        32'hA4,   5'd3,  5'b00001});
`endif
    vecs.push_back('{32'hA4,   32'h00000073, 32'h0,        32'h0,        32'h0,        32'hA8,   5'd0,  5'b00001});
    vecs.push_back('{32'h200,  32'hFFFFFFFF, 32'h0,        32'h0,        32'h0,        32'h204,  5'd31, 5'b00001});

    // Pin the model itself to a few hand-computed values
    m = model(32'h10, 32'h00500093, 32'h0, 32'h0);
    chk("model_addi_result", m.res, 32'h5);
    m = model(32'h20, 32'h004080E7, 32'h1001, 32'h0);
    chk("model_jalr_next_pc", m.npc, 32'h1004);
    m = model(32'h100, 32'hFE208EE3, 32'h7, 32'h7);
    chk("model_beq_next_pc", m.npc, 32'hFC);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_rom_addr", rom_addr, RESET_PC);
    chk("reset_completed", 32'(completed), 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_next_pc", next_pc, 32'd0);
    chk("reset_flags", 32'({reg_write, is_load, is_store, is_jump_chosen, illegal}), 32'd0);

    foreach (vecs[i]) run_vec(i, vecs[i], 1'b0);
    // A second start pulse while busy must be ignored
    run_vec(100, vecs[0], 1'b1);
    // Leave illegal=1 in the outputs, then abort an operation during FETCH
    run_vec(101, vecs[vecs.size() - 1], 1'b0);
    tb_pc = 32'h300; tb_instr = 32'h00500093;
    pc = 32'h300; enabled = 1'b1;
    @(posedge clk); #1;
    enabled = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (completed) seen = 1'b1;
    end
    chk("abort_no_completed", 32'(seen), 32'd0);
    chk("abort_rom_addr", rom_addr, RESET_PC);
    chk("abort_illegal", 32'(illegal), 32'd0);
    chk("abort_next_pc", next_pc, 32'd0);
    chk("abort_rd", 32'(rd), 32'd0);
    chk("abort_rs1_addr", 32'(rs1_addr), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
